// File: rtl/adjacency_counter.sv
// Post-placement scan: walks the 8x8 board one cell per clock and fills in
// each cell's adjacent-bomb count, tallying the total bomb population.
module adjacency_counter #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int CELL_W   = 9,
  parameter int BOMB_BIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CELL_W-1:0] board_in  [0:ROWS-1][0:COLS-1],
  output logic [CELL_W-1:0] board_out [0:ROWS-1][0:COLS-1],
  output logic [6:0]        bomb_total,
  output logic              busy,
  output logic              done,
  output logic              valid
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [6:0]        r_total;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic [CELL_W-1:0] r_board [0:ROWS-1][0:COLS-1];
  logic [CELL_W-1:0] r_snap  [0:ROWS-1][0:COLS-1];

  logic [CELL_W-1:0] w_cell;
  logic              w_bomb;
  logic [3:0]        w_cnt;
  logic [CELL_W-1:0] w_wr;
  logic              w_load;
  logic              w_unused;
  int                w_rr;
  int                w_cc;

  assign w_load = (r_state == IDLE) && start && !rst;
  assign w_cell = r_snap[r_row][r_col];
  assign w_bomb = w_cell[BOMB_BIT];

  // Only the current cell's 8 neighbours are summed; edges do not wrap.
  always_comb begin
    w_cnt = '0;
    w_rr  = 0;
    w_cc  = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        w_rr = int'(r_row) + dr;
        w_cc = int'(r_col) + dc;
        if (!(dr == 0 && dc == 0) &&
            w_rr >= 0 && w_rr < ROWS &&
            w_cc >= 0 && w_cc < COLS)
          w_cnt = w_cnt +
            4'(r_snap[w_rr[RW-1:0]][w_cc[CW-1:0]][BOMB_BIT]);
      end
    end
  end

  assign w_wr = {w_cell[CELL_W-1:5], 1'b0,
                 w_bomb ? 4'hF : w_cnt};

  always_comb begin
    w_unused = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        w_unused = w_unused ^ (^r_snap[r][c][4:0]);
  end

  always_ff @(posedge clk) begin
    if (w_load)
      r_snap <= board_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_total <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_board[r][c] <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SCAN;
            r_row   <= '0;
            r_col   <= '0;
            r_total <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        SCAN: begin
          r_board[r_row][r_col] <= w_wr;
          if (w_bomb)
            r_total <= r_total + 7'd1;
          if (r_col == CW'(COLS - 1)) begin
            r_col <= '0;
            if (r_row == RW'(ROWS - 1)) begin
              r_row   <= '0;
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_row <= r_row + RW'(1);
            end
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign board_out  = r_board;
  assign bomb_total = r_total;
  assign busy       = r_busy;
  assign done       = r_done;
  assign valid      = r_valid;

endmodule
